readout_token_ctrl: RTL



---
 rtl/readout_pkg.sv | 16 +
 rtl/readout_term_cnt.sv | 35 +++
 rtl/readout_token_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared state encoding and constants for the readout token scheduler
package readout_pkg;

    localparam int CNT_W        = 27;
    localparam int SIM_INTERVAL = 20;
    localparam int SIM_TIMEOUT  = 200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_GAP   = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

endpackage

// File: rtl/readout_term_cnt.sv
// rtl/readout_term_cnt.sv - cycle counter with sync clear/enable and terminal compare
module readout_term_cnt
    import readout_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // limit_i is the last count value of the interval, so term_o marks its final cycle
    assign term_o = (cnt_q == limit_i);

endmodule

// File: rtl/readout_token_ctrl.sv
// rtl/readout_token_ctrl.sv - token ring round scheduler with continuous mode, watchdog and round counter
module readout_token_ctrl
    import readout_pkg::*;
#(
    parameter int IntervalCyc = 1_000_000,
    parameter int TimeoutCyc  = 4_000_000,
    parameter int SimPresent  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start_i,
    input  logic        Stop_i,
    input  logic        Continuous_i,
    input  logic        Clear_i,
    output logic        TokenValid_o,
    input  logic        TokenValid_i,
    output logic        Busy_o,
    output logic        RoundDone_o,
    output logic [15:0] RoundCnt_o,
    output logic        Timeout_o,
    output logic        Spurious_o
);

    localparam int INTERVAL = (SimPresent != 0) ? SIM_INTERVAL : IntervalCyc;
    localparam int TIMEOUT  = (SimPresent != 0) ? SIM_TIMEOUT  : TimeoutCyc;
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(INTERVAL - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             stop_req_q, stop_req_d;
    logic             done_q, done_d;
    logic [15:0]      round_cnt_q, round_cnt_d;
    logic             timeout_q, timeout_d;
    logic             spurious_q, spurious_d;
    logic             cnt_clr, cnt_en, cnt_term;
    logic [CNT_W-1:0] cnt_limit;

    always_comb begin
        state_d     = state_q;
        stop_req_d  = stop_req_q;
        done_d      = 1'b0;
        round_cnt_d = round_cnt_q;
        timeout_d   = timeout_q;
        spurious_d  = spurious_q;

        if (Stop_i && state_q != ST_IDLE) stop_req_d = 1'b1;
        if (TokenValid_i && state_q != ST_WAIT) spurious_d = 1'b1;

        case (state_q)
            ST_IDLE:  if (Start_i) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // a token arriving on the watchdog's last cycle still completes the round
                if (TokenValid_i) begin
                    done_d      = 1'b1;
                    round_cnt_d = round_cnt_q + 16'd1;
                    state_d     = (Continuous_i && !stop_req_q) ? ST_GAP : ST_IDLE;
                end else if (cnt_term) begin
                    timeout_d = 1'b1;
                    state_d   = ST_ERR;
                end
            end
            ST_GAP: begin
                if (stop_req_q || Stop_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_term) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ERR: begin
                if (Clear_i) begin
                    timeout_d  = 1'b0;
                    spurious_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) stop_req_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stop_req_q  <= 1'b0;
            done_q      <= 1'b0;
            round_cnt_q <= '0;
            timeout_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_req_q  <= stop_req_d;
            done_q      <= done_d;
            round_cnt_q <= round_cnt_d;
            timeout_q   <= timeout_d;
            spurious_q  <= spurious_d;
        end
    end

    // WAIT and GAP never overlap, so one counter serves both with a state-selected limit
    assign cnt_clr   = (state_d != state_q);
    assign cnt_en    = (state_q == ST_WAIT) || (state_q == ST_GAP);
    assign cnt_limit = (state_q == ST_GAP) ? GAP_LAST : WAIT_LAST;

    readout_term_cnt u_term_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (cnt_limit),
        .term_o  (cnt_term)
    );

    assign TokenValid_o = (state_q == ST_ISSUE);
    assign Busy_o       = (state_q != ST_IDLE);
    assign RoundDone_o  = done_q;
    assign RoundCnt_o   = round_cnt_q;
    assign Timeout_o    = timeout_q;
    assign Spurious_o   = spurious_q;

endmodule
